// File: rtl/pipe_regfile_pkg.sv
// -----------------------------------------------------------------------------
// pipe_regfile_pkg
//
// Shared definitions for the decode-stage register file:
//   - state_t      : clear-sequencer state encoding (ST_INIT = 0, ST_RUN = 1)
//   - DEFAULT_*    : default register width and address width
//
// No ports (package). Imported by pipe_regfile and pipe_regfile_init_seq.
// -----------------------------------------------------------------------------
package pipe_regfile_pkg;

    // Sequencer states. ST_INIT walks the file writing zeros; ST_RUN is normal
    // operation with the write port open to writeback.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_NUM_RD = 2;

endpackage : pipe_regfile_pkg

// File: rtl/pipe_regfile_init_seq.sv
// -----------------------------------------------------------------------------
// pipe_regfile_init_seq
//
// Clear sequencer for pipe_regfile. After reset, or on a clr pulse while
// running, it steps a counter through every entry and asks the top level to
// write zero there, one entry per clock. When the last entry has been cleared
// it moves to RUN and raises ready.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset (forces INIT, cnt=0)
//   clr        in   1       clear request, honoured only in RUN
//   init_we    out  1       high while in INIT: write zero to init_addr
//   init_addr  out  ADDR_W  entry being cleared this cycle
//   ready      out  1       registered, 1 while in RUN
// -----------------------------------------------------------------------------
module pipe_regfile_init_seq
    import pipe_regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    // Single FSM block. ready is registered alongside the state so it always
    // equals (state == ST_RUN) without a combinational decode on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    // cnt wraps back to zero on the same edge that leaves INIT,
                    // so a later clr starts from a clean counter anyway.
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // While rst is held the state sits in INIT and keeps rewriting entry 0;
    // that is harmless because the whole file is cleared again afterwards.
    assign init_we   = (state == ST_INIT);
    assign init_addr = cnt;

endmodule : pipe_regfile_init_seq

// File: rtl/pipe_regfile.sv
// -----------------------------------------------------------------------------
// pipe_regfile
//
// General-purpose register file for the decode stage: one synchronous write
// port fed by writeback, NUM_RD combinational read ports, optional hardwired
// zero register, and a built-in clear sequencer that zeroes every entry after
// reset or on a clr pulse. ready goes high once the file is usable.
//
// Optional feature (compile-time macro PIPE_REGFILE_BYPASS_EN):
//   defined   : write-first. A read of the address being written this cycle
//               returns wdata immediately.
//   undefined : read-first. A read returns the old contents until after the
//               write edge; no bypass mux exists.
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   NUM_RD    number of read ports (>= 1)
//   ZERO_REG  1: entry 0 always reads 0 and ignores writes
//
// Ports:
//   clk    in   1               clock, rising edge
//   rst    in   1               synchronous active-high reset
//   clr    in   1               start a clear sequence (ignored while clearing)
//   ready  out  1               1 = file usable (RUN)
//   we     in   1               write enable
//   waddr  in   ADDR_W          write address
//   wdata  in   DATA_W          write data
//   raddr  in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata  out  NUM_RD*DATA_W   read data,      port k at [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              zero_wr;
    logic              wr_en;

    pipe_regfile_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    // A write to entry 0 is swallowed when the zero register is enabled.
    assign zero_wr = (ZERO_REG != 0) && (waddr == '0);

    // Normal writes only land in RUN; anything arriving during a clear is
    // dropped rather than queued.
    assign wr_en = ready && we && !zero_wr;

    // Storage has no reset of its own: the sequencer is the only thing that
    // zeroes it. The clear write takes priority, though wr_en is already
    // low whenever init_we is high.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
`ifdef PIPE_REGFILE_BYPASS_EN
            // wr_en already excludes suppressed zero-register writes, so the
            // bypass never forwards data that the array would not store.
            if (wr_en && (ra == waddr)) begin
                rd = wdata;
            end
`endif
            // Hide partially-cleared contents while the sequencer runs.
            if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
                rd = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule : pipe_regfile

// File: tb/tb_pipe_regfile.sv
// -----------------------------------------------------------------------------
// tb_pipe_regfile
//
// Directed testbench for pipe_regfile (DATA_W=32, ADDR_W=5, NUM_RD=3,
// ZERO_REG=1). Inputs are driven on the falling edge; combinational read data
// and ready are sampled 1 time unit later, well away from the rising edge.
// Same-cycle read-after-write expectations follow PIPE_REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_pipe_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic           clk;
    logic           rst;
    logic           clr;
    logic           ready;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;

    int checks;
    int errors;

    pipe_regfile #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .ready (ready),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] port_data(input int k);
        return rdata[k*DW +: DW];
    endfunction

    task automatic set_raddr(input int k, input logic [AW-1:0] a);
        raddr[k*AW +: AW] = a;
    endtask

    // One-cycle write issued on a falling edge; returns on the next falling
    // edge with we deasserted again.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", ready);
        end
        for (int k = 0; k < NR; k++) begin
            set_raddr(k, AW'(k + 5));
        end
        #1;
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (port_data(k) !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata%0d got %h want 00000000", k, port_data(k));
            end
        end
        // Count falling edges with ready low, starting at the one after E0.
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL reset_latency got %0d cycles want 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            set_raddr(0, AW'(a));
            #1;
            checks++;
            if (port_data(0) !== 32'h0) begin
                errors++;
                $display("FAIL reset_clear_r%0d got %h want 00000000", a, port_data(0));
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp_same;
`ifdef PIPE_REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        @(negedge clk);
        set_raddr(1, 5'd5);
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (port_data(1) !== exp_same) begin
            errors++;
            $display("FAIL wr_same_cycle got %h want %h", port_data(1), exp_same);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (port_data(1) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_next_cycle got %h want deadbeef", port_data(1));
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        set_raddr(0, 5'd0);
        set_raddr(1, 5'd0);
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'h00001234;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (port_data(k) !== 32'h0) begin
                errors++;
                $display("FAIL zero_same_p%0d got %h want 00000000", k, port_data(k));
            end
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (port_data(k) !== 32'h0) begin
                errors++;
                $display("FAIL zero_after_p%0d got %h want 00000000", k, port_data(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_write(5'd1, 32'h11111111);
        do_write(5'd2, 32'h22222222);
        do_write(5'd1, 32'h33333333);
        set_raddr(0, 5'd1);
        set_raddr(1, 5'd2);
        #1;
        checks++;
        if (port_data(0) !== 32'h33333333) begin
            errors++;
            $display("FAIL b2b_r1 got %h want 33333333", port_data(0));
        end
        checks++;
        if (port_data(1) !== 32'h22222222) begin
            errors++;
            $display("FAIL b2b_r2 got %h want 22222222", port_data(1));
        end
    endtask

    task automatic test_runtime_clear();
        int n;
        @(negedge clk);
        do_write(5'd7, 32'h00000055);
        set_raddr(0, 5'd7);
        set_raddr(1, 5'd9);
        #1;
        checks++;
        if (port_data(0) !== 32'h00000055) begin
            errors++;
            $display("FAIL clr_pre_r7 got %h want 00000055", port_data(0));
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready_low got %b want 0", ready);
        end
        // r7 is not yet cleared here, so a zero proves the INIT read mask.
        checks++;
        if (port_data(0) !== 32'h0) begin
            errors++;
            $display("FAIL clr_read_mask got %h want 00000000", port_data(0));
        end
        // Late write to r9, after the sequencer has already passed entry 9.
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            if (n == 20) begin
                we    = 1'b1;
                waddr = 5'd9;
                wdata = 32'h00000001;
            end else begin
                we = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        we = 1'b0;
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL clr_latency got %0d cycles want 32", n);
        end
        checks++;
        if (port_data(0) !== 32'h0) begin
            errors++;
            $display("FAIL clr_r7 got %h want 00000000", port_data(0));
        end
        checks++;
        if (port_data(1) !== 32'h0) begin
            errors++;
            $display("FAIL clr_r9_dropped got %h want 00000000", port_data(1));
        end
    endtask

    task automatic test_rst_mid_clear();
        int n;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        // This falling edge shows cnt=0; ten more bring the counter to 10.
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL midclr_latency got %0d cycles want 32", n);
        end
    endtask

    task automatic test_multi_port();
        @(negedge clk);
        do_write(5'd3, 32'hA5A5A5A5);
        do_write(5'd4, 32'h5A5A5A5A);
        set_raddr(0, 5'd3);
        set_raddr(1, 5'd4);
        set_raddr(2, 5'd3);
        #1;
        checks++;
        if (port_data(0) !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL mp_p0 got %h want a5a5a5a5", port_data(0));
        end
        checks++;
        if (port_data(1) !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL mp_p1 got %h want 5a5a5a5a", port_data(1));
        end
        checks++;
        if (port_data(2) !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL mp_p2 got %h want a5a5a5a5", port_data(2));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clr    = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;

        test_reset();
        test_write_read();
        test_zero_reg();
        test_back_to_back();
        test_runtime_clear();
        test_rst_mid_clear();
        test_multi_port();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_regfile
